// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-to-1 valid/ready stream mux, fixed-select or round-robin, one output register.
// Optional packet lock (Mode=1 holds the grant until InLast) under `STREAM_MUX_PKT_LOCK_EN.
module stream_mux_rr #(
   parameter  int W  = 32,
   parameter  int N  = 4,
   localparam int SW = $clog2(N)
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic [N*W-1:0] In,
   input  logic [N-1:0]   InValid,
   output logic [N-1:0]   InReady,
   input  logic [SW-1:0]  Sel,
   input  logic           Mode,
`ifdef STREAM_MUX_PKT_LOCK_EN
   input  logic [N-1:0]   InLast,
   output logic           OutLast,
`endif
   output logic [W-1:0]   Out,
   output logic           OutValid,
   input  logic           OutReady,
   output logic [SW-1:0]  OutSrc
);

   logic          load;
   logic          gnt_valid;
   logic [SW-1:0] gnt;
   logic [SW-1:0] last;
   logic [W-1:0]  gnt_data;
`ifdef STREAM_MUX_PKT_LOCK_EN
   logic          locked;
   logic [SW-1:0] lock_ch;
`endif

   assign load = !OutValid || OutReady;

   always_comb begin
      gnt_valid = 1'b0;
      gnt       = '0;
      if (!Mode) begin
         // Sel values at or beyond N match no channel, so nothing is granted.
         for (int i = 0; i < N; i++) begin
            if (Sel == SW'(i) && InValid[i]) begin
               gnt_valid = 1'b1;
               gnt       = SW'(i);
            end
         end
      end
`ifdef STREAM_MUX_PKT_LOCK_EN
      else if (locked) begin
         gnt_valid = InValid[lock_ch];
         gnt       = lock_ch;
      end
`endif
      else begin
         // Scan farthest-first so the channel nearest after Last wins.
         for (int k = N; k >= 1; k--) begin
            if (InValid[(int'(last) + k) % N]) begin
               gnt_valid = 1'b1;
               gnt       = SW'((int'(last) + k) % N);
            end
         end
      end
   end

   always_comb begin
      gnt_data = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt == SW'(i)) gnt_data = In[i*W +: W];
      end
   end

   always_comb begin
      InReady = '0;
      if (!Reset && load && gnt_valid) InReady[gnt] = 1'b1;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Out      <= '0;
         OutValid <= 1'b0;
         OutSrc   <= '0;
         last     <= SW'(N - 1);
`ifdef STREAM_MUX_PKT_LOCK_EN
         OutLast  <= 1'b0;
         locked   <= 1'b0;
         lock_ch  <= '0;
`endif
      end else if (load) begin
         OutValid <= gnt_valid;
         if (gnt_valid) begin
            Out    <= gnt_data;
            OutSrc <= gnt;
`ifdef STREAM_MUX_PKT_LOCK_EN
            OutLast <= InLast[gnt];
`endif
            if (Mode) begin
               last <= gnt;
`ifdef STREAM_MUX_PKT_LOCK_EN
               locked  <= !InLast[gnt];
               lock_ch <= gnt;
`endif
            end
         end
      end
   end

endmodule
